// File: rtl/csr_uart.sv
// CSR-mapped 8N1 console UART: the core writes bytes to ADDR for transmission and reads
// received data/status from ADDR, with the response returned one cycle after the read.
module csr_uart #(
  parameter int          CLOCK_RATE = 24_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter logic [11:0] ADDR       = 12'hbc0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_read,
  input  logic [2:0]  csr_modify,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  output logic        csr_valid,
  input  logic        rx,
  output logic        tx
);
  localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
  localparam int CW      = $clog2(DIVIDER);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVIDER / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic rd_hit, wr_hit, tx_busy;
  assign rd_hit  = csr_read && (csr_addr == ADDR);
  assign wr_hit  = (csr_modify == 3'd1) && (csr_addr == ADDR);

  logic unused_wdata;
  assign unused_wdata = ^csr_wdata[31:8];

  // ---------------- TX ----------------
  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, tx_adv;

  assign tx_busy = (tx_state_q != S_IDLE);
  assign tx_adv  = (tx_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      S_IDLE: if (wr_hit) begin
        tx_state_d = S_START;
        tx_sh_d    = csr_wdata[7:0];
        tx_cnt_d   = '0;
      end
      S_START: if (tx_adv) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_DATA: if (tx_adv) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
        end
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_STOP: if (tx_adv) begin
        tx_cnt_d   = '0;
        tx_state_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so the registered pin lines up with the FSM state.
  always_comb begin
    tx_d = 1'b1;
    if (tx_state_d == S_START)     tx_d = 1'b0;
    else if (tx_state_d == S_DATA) tx_d = tx_sh_d[0];
  end

  assign tx = tx_q;

  // ---------------- RX ----------------
  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_arm_q, rx_arm_d;
  logic          rx_s, rx_done;

  assign rx_sync_d = {rx_sync_q[0], rx};
  assign rx_s      = rx_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_sync_q  <= 2'b11;
      rx_arm_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_sync_q  <= rx_sync_d;
      rx_arm_q   <= rx_arm_d;
    end
  end

  // rx_arm keeps a line stuck low after a framing error from re-triggering a start bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_arm_d   = rx_arm_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_arm_q)  rx_arm_d   = rx_s;
        else if (!rx_s) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_DATA: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_STOP: if (rx_cnt_q == DIV_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (rx_s) rx_done  = 1'b1;
        else      rx_arm_d = 1'b0;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- buffer, flags, response ----------------
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_full_q, rx_full_d, rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q <= '0;
      rx_full_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      tx_ovr_q  <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rx_byte_q <= rx_byte_d;
      rx_full_q <= rx_full_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_ovr_q  <= tx_ovr_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    rx_byte_d = rx_byte_q;
    rx_full_d = rd_hit ? 1'b0 : rx_full_q;
    rx_ovr_d  = rd_hit ? 1'b0 : rx_ovr_q;
    tx_ovr_d  = rd_hit ? 1'b0 : tx_ovr_q;
    if (wr_hit && tx_busy) tx_ovr_d = 1'b1;
    if (rx_done) begin
      rx_byte_d = rx_sh_q;
      rx_full_d = 1'b1;
      if (rx_full_q && !rd_hit) rx_ovr_d = 1'b1;
    end
    valid_d = rd_hit;
    rdata_d = rd_hit ? {20'b0, rx_ovr_q, tx_ovr_q, tx_busy, rx_full_q, rx_byte_q} : 32'b0;
  end

  assign csr_valid = valid_q;
  assign csr_rdata = rdata_q;
endmodule

// File: tb/tb_csr_uart.sv
// Directed bench for csr_uart at DIVIDER=10: a CSR vector table plus hand-timed TX/RX frames.
module tb_csr_uart;
  localparam logic [11:0] ADDR = 12'hbc0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_read = 1'b0;
  logic [2:0]  csr_modify = 3'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic [11:0] csr_addr = ADDR;
  logic [31:0] csr_rdata;
  logic        csr_valid;
  logic        rx = 1'b1;
  logic        tx;

  int checks = 0;
  int errors = 0;

  csr_uart #(.CLOCK_RATE(100), .BAUD_RATE(10), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .csr_read(csr_read), .csr_modify(csr_modify),
    .csr_wdata(csr_wdata), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_valid(csr_valid), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [2:0]  mod;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Read ADDR for one cycle; an absent response shows up as all-ones.
  task automatic do_read(output logic [31:0] v);
    csr_read = 1'b1; csr_addr = ADDR;
    step();
    csr_read = 1'b0;
    v = csr_valid ? csr_rdata : 32'hffff_ffff;
  endtask

  // Drive one 100-cycle frame; optionally read ADDR during cycle rd_at of the frame.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int rd_at,
                          output logic [31:0] rd_val);
    rd_val = 32'h0;
    for (int i = 0; i < 100; i++) begin
      if (i < 10)      rx = 1'b0;
      else if (i < 90) rx = b[(i-10)/10];
      else             rx = stop;
      csr_read = (i == rd_at); csr_addr = ADDR;
      step();
      if (i == rd_at) rd_val = csr_valid ? csr_rdata : 32'hdead_beef;
      csr_read = 1'b0;
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  txb;
    logic        exp_tx;
    int          bad;

    vecs[0] = '{1'b1, 3'd0, 12'hbc0, 32'h0,  1'b1, 32'h0};
    vecs[1] = '{1'b1, 3'd0, 12'h3ff, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 3'd2, 12'hbc0, 32'h5A, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 3'd0, 12'hbc0, 32'h0,  1'b1, 32'h0};
    vecs[4] = '{1'b0, 3'd1, 12'h3ff, 32'h55, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 3'd0, 12'hbc0, 32'h0,  1'b1, 32'h0};
    vecs[6] = '{1'b0, 3'd0, 12'hbc0, 32'h0,  1'b0, 32'h0};

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_valid", {31'b0, csr_valid}, 32'h0);
    check("reset_rdata", csr_rdata, 32'h0);

    foreach (vecs[i]) begin
      csr_read = vecs[i].rd; csr_modify = vecs[i].mod;
      csr_addr = vecs[i].addr; csr_wdata = vecs[i].wdata;
      step();
      csr_read = 1'b0; csr_modify = 3'd0; csr_addr = ADDR;
      check($sformatf("vec%0d_valid", i), {31'b0, csr_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_tx", i), {31'b0, tx}, 32'h1);
    end

    // TX frame of 0xA5 with an overrun write, status reads, busy boundary.
    txb = 8'hA5;
    csr_modify = 3'd1; csr_addr = ADDR; csr_wdata = 32'h1A5;
    step();
    csr_modify = 3'd0;
    bad = 0;
    for (int k = 1; k <= 101; k++) begin
      if (k <= 10)      exp_tx = 1'b0;
      else if (k <= 90) exp_tx = txb[(k-11)/10];
      else              exp_tx = 1'b1;
      if (tx !== exp_tx) bad++;
      csr_read   = (k == 50 || k == 60 || k == 100 || k == 101);
      csr_modify = (k == 30) ? 3'd1 : 3'd0;
      csr_wdata  = 32'h42;
      step();
      csr_modify = 3'd0;
      if (csr_read) begin
        v = csr_valid ? csr_rdata : 32'hffff_ffff;
        case (k)
          50:  check("tx_mid_busy_ovr", v, 32'h600);
          60:  check("tx_ovr_cleared", v, 32'h200);
          100: check("tx_last_stop_busy", v, 32'h200);
          default: check("tx_busy_clear", v, 32'h000);
        endcase
      end
      csr_read = 1'b0;
    end
    check("tx_frame_bits_wrong", bad, 0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx !== 1'b1) bad++;
      step();
    end
    check("tx_no_extra_frame", bad, 0);

    // RX single byte, then pop.
    rx_frame(8'h3C, 1'b1, -1, v);
    idle(5);
    do_read(v); check("rx_3c_full", v, 32'h13C);
    do_read(v); check("rx_3c_popped", v, 32'h03C);

    // RX overrun.
    rx_frame(8'h11, 1'b1, -1, v);
    rx_frame(8'h22, 1'b1, -1, v);
    idle(5);
    do_read(v); check("rx_overrun", v, 32'h922);
    do_read(v); check("rx_overrun_cleared", v, 32'h022);

    // Framing error, then a short glitch, then recovery.
    rx_frame(8'h77, 1'b0, -1, v);
    idle(5);
    do_read(v); check("rx_framing_err", v, 32'h022);
    rx = 1'b0; idle(4); rx = 1'b1; idle(20);
    do_read(v); check("rx_glitch", v, 32'h022);
    rx_frame(8'h5A, 1'b1, -1, v);
    idle(5);
    do_read(v); check("rx_recover", v, 32'h15A);
    do_read(v); check("rx_recover_pop", v, 32'h05A);

    // Pop on the exact stop-sample cycle of the next byte.
    rx_frame(8'h55, 1'b1, -1, v);
    idle(3);
    rx_frame(8'h66, 1'b1, 97, v);
    check("rx_pop_at_stop_old", v, 32'h155);
    idle(3);
    do_read(v); check("rx_pop_at_stop_new", v, 32'h166);
    do_read(v); check("rx_pop_at_stop_pop", v, 32'h066);

    // Reset mid-frame with a full buffer and a read in flight.
    rx_frame(8'h33, 1'b1, -1, v);
    idle(5);
    csr_modify = 3'd1; csr_wdata = 32'h00; csr_addr = ADDR;
    step();
    csr_modify = 3'd0;
    idle(25);
    check("pre_rst_tx_low", {31'b0, tx}, 32'h0);
    rst = 1'b1; csr_read = 1'b1;
    step();
    rst = 1'b0; csr_read = 1'b0;
    check("rst_mid_tx", {31'b0, tx}, 32'h1);
    check("rst_mid_valid", {31'b0, csr_valid}, 32'h0);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx !== 1'b1) bad++;
      step();
    end
    check("rst_frame_abandoned", bad, 0);
    do_read(v); check("rst_cleared_status", v, 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
